// File: rtl/execute_writeback.sv
// execute_writeback: execute (stage 2) and writeback (stage 3) of the
// 3-stage Riscv151 pipeline.
//
// Stage 2 (combinational): operand select with stage-3 forwarding, ALU,
// branch/jump resolution, dcache request generation. The tohost CSR is
// written at the end of this stage.
// Stage 3 (registered): result capture, load lane extraction and the
// register-file write port that feeds DecodeRead.
//
// Ports
//   clk, reset           rising-edge clock, async active-low reset
//   stall                memory stall, freezes all state
//   pc/reg_a/reg_b/imm   stage-2 operands
//   alu_op, add_rshift_type, shift_imm, a_sel, b_sel   ALU control
//   is_lui/is_branch/is_jal/is_jalr, funct3            instruction class
//   reg_we/mem_we/mem_rr, rd/rs1/rs2                   effects and indices
//   csr_write, csr_imm   csrrw(i) to tohost
//   pc_select/alu_result/bubble   to ProgramCounter / DecodeRead
//   dcache_*             data cache request and load data
//   rf_we/rf_wa/rf_wd    register-file write port
//   csr                  tohost register
module execute_writeback #(
  parameter bit          FWD_EN    = 1'b1,
  parameter logic [31:0] CSR_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic [31:0] reg_a,
  input  logic [31:0] reg_b,
  input  logic [31:0] imm,
  input  logic [3:0]  alu_op,
  input  logic        add_rshift_type,
  input  logic        shift_imm,
  input  logic        a_sel,
  input  logic        b_sel,
  input  logic        is_lui,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic [2:0]  funct3,
  input  logic        reg_we,
  input  logic        mem_we,
  input  logic        mem_rr,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        csr_write,
  input  logic        csr_imm,
  output logic        pc_select,
  output logic [31:0] alu_result,
  output logic        bubble,
  output logic [31:0] dcache_addr,
  output logic [3:0]  dcache_we,
  output logic        dcache_re,
  output logic [31:0] dcache_din,
  input  logic [31:0] dcache_dout,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] csr
);

  // Stage-3 and control state
  logic        squash_q, squash_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_wa_q, rf_wa_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] pc4_q, pc4_d;
  logic        load_q, load_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic        jump_q, jump_d;
  logic [31:0] csr_q, csr_d;

  // Execute-stage signals
  logic        valid;
  logic        hit1, hit2;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  logic        use_f7;
  logic [31:0] alu_out;
  logic        cond;
  logic        taken;
  logic [1:0]  off;
  logic [3:0]  st_mask;
  logic [31:0] lane;
  logic [31:0] load_val;

  assign valid = !squash_q;

  // Forward the value being written back this cycle; x0 never forwards.
  assign hit1    = FWD_EN && rf_we_q && (rf_wa_q == rs1) && (rs1 != '0);
  assign hit2    = FWD_EN && rf_we_q && (rf_wa_q == rs2) && (rs2 != '0);
  assign rs1_val = hit1 ? rf_wd : reg_a;
  assign rs2_val = hit2 ? rf_wd : reg_b;

  always_comb begin
    op_a = rs1_val;
    if (is_lui)     op_a = '0;
    else if (a_sel) op_a = pc;
    op_b = rs2_val;
    if (shift_imm)  op_b = {27'b0, imm[4:0]};
    else if (b_sel) op_b = imm;
  end

  assign shamt = op_b[4:0];
  // funct7[5] only means SUB/SRA for register ops and immediate shifts;
  // for the other OP-IMM forms that bit belongs to the immediate.
  assign use_f7 = !b_sel || shift_imm;

  always_comb begin
    alu_out = op_a + op_b;
    if (!alu_op[3]) begin
      unique case (alu_op[2:0])
        3'b000: alu_out = (use_f7 && add_rshift_type) ? op_a - op_b : op_a + op_b;
        3'b001: alu_out = op_a << shamt;
        3'b010: alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
        3'b011: alu_out = {31'b0, op_a < op_b};
        3'b100: alu_out = op_a ^ op_b;
        3'b101: alu_out = (use_f7 && add_rshift_type) ?
                          32'($signed(op_a) >>> shamt) : op_a >> shamt;
        3'b110: alu_out = op_a | op_b;
        default: alu_out = op_a & op_b;
      endcase
    end
  end

  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = rs1_val == rs2_val;
      3'b001:  cond = rs1_val != rs2_val;
      3'b100:  cond = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  cond = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  cond = rs1_val < rs2_val;
      3'b111:  cond = rs1_val >= rs2_val;
      default: cond = 1'b0;
    endcase
  end

  assign taken      = valid && (is_jal || is_jalr || (is_branch && cond));
  assign pc_select  = taken;
  assign bubble     = taken || squash_q;
  assign alu_result = {alu_out[31:1], alu_out[0] & ~is_jalr};

  // Data cache request
  assign off         = alu_result[1:0];
  assign dcache_addr = {alu_result[31:2], 2'b00};
  always_comb begin
    case (funct3[1:0])
      2'b00:   st_mask = 4'b0001;
      2'b01:   st_mask = 4'b0011;
      default: st_mask = 4'b1111;
    endcase
  end
  assign dcache_we  = (valid && mem_we) ? (st_mask << off) : '0;
  assign dcache_din = rs2_val << {off, 3'b000};
  assign dcache_re  = valid && mem_rr;

  // Next-state for stage 3 and control
  always_comb begin
    squash_d = taken;
    rf_we_d  = valid && reg_we && (rd != '0);
    rf_wa_d  = rd;
    alu_d    = alu_result;
    pc4_d    = pc + 32'd4;
    load_d   = valid && mem_rr;
    funct3_d = funct3;
    off_d    = off;
    jump_d   = is_jal || is_jalr;
    csr_d    = csr_q;
    if (valid && csr_write) csr_d = csr_imm ? {27'b0, rs1} : rs1_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      squash_q <= 1'b0;
      rf_we_q  <= 1'b0;
      rf_wa_q  <= '0;
      alu_q    <= '0;
      pc4_q    <= '0;
      load_q   <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
      jump_q   <= 1'b0;
      csr_q    <= CSR_RESET;
    end else if (!stall) begin
      squash_q <= squash_d;
      rf_we_q  <= rf_we_d;
      rf_wa_q  <= rf_wa_d;
      alu_q    <= alu_d;
      pc4_q    <= pc4_d;
      load_q   <= load_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      jump_q   <= jump_d;
      csr_q    <= csr_d;
    end
  end

  // Load lane extraction in stage 3
  assign lane = dcache_dout >> {off_q, 3'b000};
  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'b0, lane[7:0]};
      3'b101:  load_val = {16'b0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = jump_q ? pc4_q : (load_q ? load_val : alu_q);
  assign csr   = csr_q;

endmodule

// File: tb/tb_execute_writeback.sv
module tb_execute_writeback;
  logic        clk = 1'b0;
  logic        reset, stall;
  logic [31:0] pc, reg_a, reg_b, imm, dcache_dout;
  logic [3:0]  alu_op;
  logic        add_rshift_type, shift_imm, a_sel, b_sel;
  logic        is_lui, is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic        reg_we, mem_we, mem_rr, csr_write, csr_imm;
  logic [4:0]  rd, rs1, rs2;

  logic        pc_select, bubble, dcache_re, rf_we;
  logic [31:0] alu_result, dcache_addr, dcache_din, rf_wd, csr;
  logic [3:0]  dcache_we;
  logic [4:0]  rf_wa;

  logic        n_pc_select, n_bubble, n_dcache_re, n_rf_we;
  logic [31:0] n_alu_result, n_dcache_addr, n_dcache_din, n_rf_wd, n_csr;
  logic [3:0]  n_dcache_we;
  logic [4:0]  n_rf_wa;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  execute_writeback #(.FWD_EN(1'b1), .CSR_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc(pc), .reg_a(reg_a), .reg_b(reg_b),
    .imm(imm), .alu_op(alu_op), .add_rshift_type(add_rshift_type), .shift_imm(shift_imm),
    .a_sel(a_sel), .b_sel(b_sel), .is_lui(is_lui), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .funct3(funct3), .reg_we(reg_we), .mem_we(mem_we), .mem_rr(mem_rr),
    .rd(rd), .rs1(rs1), .rs2(rs2), .csr_write(csr_write), .csr_imm(csr_imm),
    .pc_select(pc_select), .alu_result(alu_result), .bubble(bubble),
    .dcache_addr(dcache_addr), .dcache_we(dcache_we), .dcache_re(dcache_re),
    .dcache_din(dcache_din), .dcache_dout(dcache_dout), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .csr(csr));

  execute_writeback #(.FWD_EN(1'b0), .CSR_RESET(32'hDEADBEEF)) dut_nofwd (
    .clk(clk), .reset(reset), .stall(stall), .pc(pc), .reg_a(reg_a), .reg_b(reg_b),
    .imm(imm), .alu_op(alu_op), .add_rshift_type(add_rshift_type), .shift_imm(shift_imm),
    .a_sel(a_sel), .b_sel(b_sel), .is_lui(is_lui), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .funct3(funct3), .reg_we(reg_we), .mem_we(mem_we), .mem_rr(mem_rr),
    .rd(rd), .rs1(rs1), .rs2(rs2), .csr_write(csr_write), .csr_imm(csr_imm),
    .pc_select(n_pc_select), .alu_result(n_alu_result), .bubble(n_bubble),
    .dcache_addr(n_dcache_addr), .dcache_we(n_dcache_we), .dcache_re(n_dcache_re),
    .dcache_din(n_dcache_din), .dcache_dout(dcache_dout), .rf_we(n_rf_we), .rf_wa(n_rf_wa),
    .rf_wd(n_rf_wd), .csr(n_csr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nop();
    pc = '0; reg_a = '0; reg_b = '0; imm = '0; alu_op = '0;
    add_rshift_type = 1'b0; shift_imm = 1'b0; a_sel = 1'b0; b_sel = 1'b0;
    is_lui = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0; funct3 = '0;
    reg_we = 1'b0; mem_we = 1'b0; mem_rr = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    csr_write = 1'b0; csr_imm = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nop(); stall = 1'b0; dcache_dout = '0; reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_wa", 32'(rf_wa), 32'd0);
    check("rst_csr", csr, 32'h0);
    check("rst_csr_nofwd", n_csr, 32'hDEADBEEF);
    check("rst_pc_select", 32'(pc_select), 32'd0);
    check("rst_bubble", 32'(bubble), 32'd0);
    check("rst_dcache_we", 32'(dcache_we), 32'd0);
    check("rst_dcache_re", 32'(dcache_re), 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // add x1 = 5 + 7, then sub x2 = x1 - 2 with a stale reg_a
    nop(); rs1 = 5'd3; reg_a = 32'd5; rs2 = 5'd4; reg_b = 32'd7; rd = 5'd1; reg_we = 1'b1;
    #1 check("add_alu", alu_result, 32'd12);
    tick();
    check("add_rf_wd", rf_wd, 32'd12);
    check("add_rf_we", 32'(rf_we), 32'd1);
    check("add_rf_wa", 32'(rf_wa), 32'd1);
    nop(); rs1 = 5'd1; reg_a = 32'd999; rs2 = 5'd5; reg_b = 32'd2;
    add_rshift_type = 1'b1; rd = 5'd2; reg_we = 1'b1;
    #1 check("sub_fwd_alu", alu_result, 32'd10);
    check("sub_nofwd_alu", n_alu_result, 32'd997);
    tick();
    check("sub_rf_wd", rf_wd, 32'd10);
    check("sub_nofwd_rf_wd", n_rf_wd, 32'd997);

    // write to x0 never enables the register file
    nop(); reg_we = 1'b1; rd = 5'd0; rs1 = 5'd4; reg_a = 32'd3;
    tick();
    check("x0_rf_we", 32'(rf_we), 32'd0);

    // taken beq, then a squashed slot that tries every side effect
    nop(); pc = 32'h100; imm = 32'h20; alu_op = 4'b1000; a_sel = 1'b1; b_sel = 1'b1;
    is_branch = 1'b1; funct3 = 3'b000; rs1 = 5'd6; rs2 = 5'd7; reg_a = 32'h55; reg_b = 32'h55;
    #1 check("beq_pc_select", 32'(pc_select), 32'd1);
    check("beq_target", alu_result, 32'h120);
    check("beq_bubble", 32'(bubble), 32'd1);
    tick();
    nop(); reg_we = 1'b1; rd = 5'd3; mem_we = 1'b1; mem_rr = 1'b1; funct3 = 3'b010;
    is_jal = 1'b1; csr_write = 1'b1; csr_imm = 1'b1; rs1 = 5'd9;
    #1 check("squash_bubble", 32'(bubble), 32'd1);
    check("squash_pc_select", 32'(pc_select), 32'd0);
    check("squash_dcache_we", 32'(dcache_we), 32'd0);
    check("squash_dcache_re", 32'(dcache_re), 32'd0);
    tick();
    nop();
    #1 check("post_squash_bubble", 32'(bubble), 32'd0);
    check("squash_rf_we", 32'(rf_we), 32'd0);
    check("squash_csr", csr, 32'h0);

    // branch conditions
    nop(); pc = 32'h200; imm = 32'h8; alu_op = 4'b1000; a_sel = 1'b1; b_sel = 1'b1;
    is_branch = 1'b1; rs1 = 5'd6; rs2 = 5'd7; funct3 = 3'b001; reg_a = 32'd7; reg_b = 32'd7;
    #1 check("bne_pc_select", 32'(pc_select), 32'd0);
    check("bne_bubble", 32'(bubble), 32'd0);
    funct3 = 3'b110; reg_a = 32'hFFFFFFFF; reg_b = 32'd1;
    #1 check("bltu_pc_select", 32'(pc_select), 32'd0);
    funct3 = 3'b100;
    #1 check("blt_pc_select", 32'(pc_select), 32'd1);
    tick(); nop(); tick();

    // addi x5 = 0x33, then sh held by a 3-cycle stall
    nop(); rs1 = 5'd1; reg_a = 32'h11; b_sel = 1'b1; imm = 32'h22; reg_we = 1'b1; rd = 5'd5;
    tick();
    nop(); mem_we = 1'b1; funct3 = 3'b001; rs1 = 5'd8; reg_a = 32'h1000; imm = 32'h2;
    b_sel = 1'b1; alu_op = 4'b1000; rs2 = 5'd9; reg_b = 32'hABCD1234;
    #1 check("sh_we", 32'(dcache_we), 32'hC);
    check("sh_din", dcache_din, 32'h12340000);
    check("sh_addr", dcache_addr, 32'h1000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_we", 32'(dcache_we), 32'hC);
      check("stall_din", dcache_din, 32'h12340000);
      check("stall_rf_wd", rf_wd, 32'h33);
      check("stall_rf_wa", 32'(rf_wa), 32'd5);
      check("stall_rf_we", 32'(rf_we), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("sh_rf_we", 32'(rf_we), 32'd0);
    check("sh_rf_wd", rf_wd, 32'h1002);

    // lb at 0x1003, consumed by the very next instruction
    nop(); mem_rr = 1'b1; funct3 = 3'b000; reg_we = 1'b1; rd = 5'd6; rs1 = 5'd8;
    reg_a = 32'h1000; imm = 32'h3; b_sel = 1'b1; alu_op = 4'b1000;
    #1 check("lb_re", 32'(dcache_re), 32'd1);
    check("lb_addr", dcache_addr, 32'h1000);
    tick();
    nop(); dcache_dout = 32'h80FFFFFF; rs1 = 5'd6; rs2 = 5'd0; reg_b = 32'd1; rd = 5'd7; reg_we = 1'b1;
    #1 check("lb_rf_wd", rf_wd, 32'hFFFFFF80);
    check("load_use_alu", alu_result, 32'hFFFFFF81);
    tick();
    check("load_use_rf_wd", rf_wd, 32'hFFFFFF81);
    nop(); mem_rr = 1'b1; funct3 = 3'b101; reg_we = 1'b1; rd = 5'd6; rs1 = 5'd8;
    reg_a = 32'h1000; imm = 32'h2; b_sel = 1'b1; alu_op = 4'b1000;
    tick();
    nop();
    #1 check("lhu_rf_wd", rf_wd, 32'h000080FF);
    tick();

    // jalr x1, 9(x5)
    nop(); pc = 32'h40; is_jalr = 1'b1; rs1 = 5'd5; reg_a = 32'h200; imm = 32'h9;
    b_sel = 1'b1; alu_op = 4'b1000; reg_we = 1'b1; rd = 5'd1;
    #1 check("jalr_target", alu_result, 32'h208);
    check("jalr_pc_select", 32'(pc_select), 32'd1);
    tick();
    nop();
    #1 check("jalr_rf_wd", rf_wd, 32'h44);
    check("jalr_rf_wa", 32'(rf_wa), 32'd1);
    check("jalr_bubble", 32'(bubble), 32'd1);
    tick();

    // csrrwi 5, then csrrw from a register
    nop(); csr_write = 1'b1; csr_imm = 1'b1; rs1 = 5'd5;
    tick();
    check("csrrwi", csr, 32'd5);
    nop(); csr_write = 1'b1; rs1 = 5'd7; reg_a = 32'hCAFEF00D;
    tick();
    check("csrrw", csr, 32'hCAFEF00D);

    // jal, then asynchronous reset while squashing
    nop(); pc = 32'h80; imm = 32'h10; is_jal = 1'b1; a_sel = 1'b1; b_sel = 1'b1;
    alu_op = 4'b1000; reg_we = 1'b1; rd = 5'd2;
    tick();
    nop();
    #1 check("jal_bubble", 32'(bubble), 32'd1);
    check("jal_rf_wd", rf_wd, 32'h84);
    #2 reset = 1'b0;
    #1 check("arst_rf_we", 32'(rf_we), 32'd0);
    check("arst_rf_wa", 32'(rf_wa), 32'd0);
    check("arst_bubble", 32'(bubble), 32'd0);
    check("arst_csr", csr, 32'h0);
    check("arst_csr_nofwd", n_csr, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
